// File: rtl/seq_match_event_counter_pkg.sv
// seq_match_event_counter_pkg
//   Shared definitions for the match event counter slice. Holds the FSM state
//   encoding and the default widths used by the top-level parameters.
package seq_match_event_counter_pkg;

    localparam int unsigned DEFAULT_CNT_W = 8;
    localparam int unsigned DEFAULT_WIN_W = 16;
    localparam int unsigned DEFAULT_TS_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        ALARM = 2'b10
    } state_e;

endpackage

// File: rtl/seq_match_event_counter_sat.sv
// seq_sat_counter
//   Parameterised up-counter with synchronous clear and optional saturation.
//   Ports:
//     clk      in   clock (rising edge)
//     rst      in   asynchronous active-high reset, count returns to 0
//     clr_i    in   synchronous clear, wins over inc_i
//     inc_i    in   increment request
//     count_o  out  current count (W bits)
//   SATURATE=1 holds the count at all-ones; SATURATE=0 wraps.
module seq_sat_counter #(
    parameter int unsigned W        = 8,
    parameter bit          SATURATE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !(SATURATE && (count_q == '1))) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_match_event_counter.sv
// seq_match_event_counter
//   Turns the level output of a Moore sequence detector into single-cycle match
//   events, counts them per programmable window, raises a sticky alarm when the
//   per-window count reaches a threshold, and keeps a saturating lifetime count.
//   Ports:
//     clk            in   clock (rising edge)
//     rst            in   asynchronous active-high reset
//     det_in         in   detector level
//     en             in   enable windowed monitoring
//     clr            in   synchronous clear of counters, alarm and FSM
//     window_len     in   window length in cycles (0 = never closes)
//     threshold      in   alarm threshold (0 = alarm disabled)
//     match_pulse    out  registered one-cycle pulse per rising edge of det_in
//     win_count      out  events in the current window (saturating)
//     total_count    out  lifetime events (saturating)
//     window_done    out  one-cycle pulse when a window closes without alarm
//     alarm          out  sticky alarm flag
//     last_match_ts  out  timestamp of the latest event
//   Build option: define MATCH_TIMESTAMP_EN to build the free-running timestamp
//   counter; otherwise last_match_ts is tied to 0.
module seq_match_event_counter
    import seq_match_event_counter_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W,
    parameter int unsigned WIN_W = DEFAULT_WIN_W,
    parameter int unsigned TS_W  = DEFAULT_TS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det_in,
    input  logic             en,
    input  logic             clr,
    input  logic [WIN_W-1:0] window_len,
    input  logic [CNT_W-1:0] threshold,
    output logic             match_pulse,
    output logic [CNT_W-1:0] win_count,
    output logic [CNT_W-1:0] total_count,
    output logic             window_done,
    output logic             alarm,
    output logic [TS_W-1:0]  last_match_ts
);

    state_e           state_q, state_d;
    logic             det_q;
    logic             rise;
    logic             match_pulse_q;
    logic             window_done_q, window_done_d;
    logic             alarm_q, alarm_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             win_clr, win_inc;
    logic [CNT_W-1:0] win_post;
    logic             win_last;

    // det_q resets high so a level already present at reset release is not an event.
    assign rise = det_in & ~det_q;

    // Window count as it would be after this cycle's rise, saturating.
    assign win_post = (rise && (win_count != '1)) ? win_count + CNT_W'(1) : win_count;
    assign win_last = (window_len != '0) && (win_cnt_q == window_len - WIN_W'(1));

    // Priority in RUN: alarm, then window close, then en drop, then normal count.
    always_comb begin
        state_d       = state_q;
        win_cnt_d     = win_cnt_q;
        alarm_d       = alarm_q;
        window_done_d = 1'b0;
        win_clr       = 1'b0;
        win_inc       = 1'b0;
        if (clr) begin
            state_d   = IDLE;
            win_cnt_d = '0;
            win_clr   = 1'b1;
            alarm_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    win_cnt_d = '0;
                    win_clr   = 1'b1;
                    if (en) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if ((threshold != '0) && (win_post >= threshold)) begin
                        state_d = ALARM;
                        alarm_d = 1'b1;
                        win_inc = rise;
                    end else if (win_last) begin
                        window_done_d = 1'b1;
                        win_cnt_d     = '0;
                        win_clr       = 1'b1;
                        state_d       = en ? RUN : IDLE;
                    end else if (!en) begin
                        state_d   = IDLE;
                        win_cnt_d = '0;
                        win_clr   = 1'b1;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        win_inc   = rise;
                    end
                end
                ALARM: begin
                    // Only clr or rst leave ALARM; counters are frozen.
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            det_q         <= 1'b1;
            match_pulse_q <= 1'b0;
            window_done_q <= 1'b0;
            alarm_q       <= 1'b0;
            win_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            det_q         <= det_in;
            match_pulse_q <= rise;
            window_done_q <= window_done_d;
            alarm_q       <= alarm_d;
            win_cnt_q     <= win_cnt_d;
        end
    end

    seq_sat_counter #(
        .W        (CNT_W),
        .SATURATE (1'b1)
    ) u_total_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .inc_i   (rise),
        .count_o (total_count)
    );

    seq_sat_counter #(
        .W        (CNT_W),
        .SATURATE (1'b1)
    ) u_win_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (win_clr),
        .inc_i   (win_inc),
        .count_o (win_count)
    );

`ifdef MATCH_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] last_ts_q, last_ts_d;

    always_comb begin
        last_ts_d = last_ts_q;
        if (clr) begin
            last_ts_d = '0;
        end else if (rise) begin
            last_ts_d = ts_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q      <= '0;
            last_ts_q <= '0;
        end else begin
            ts_q      <= ts_q + TS_W'(1);
            last_ts_q <= last_ts_d;
        end
    end

    assign last_match_ts = last_ts_q;
`else
    assign last_match_ts = '0;
`endif

    assign match_pulse = match_pulse_q;
    assign window_done = window_done_q;
    assign alarm       = alarm_q;

endmodule

// File: tb/tb_seq_match_event_counter.sv
// tb_seq_match_event_counter
//   Self-checking bench for seq_match_event_counter: directed scenarios plus a
//   randomized run compared against an integer-level reference model.
module tb_seq_match_event_counter;

    localparam int CW = 8;
    localparam int WW = 16;
    localparam int TW = 32;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          det_in = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic [WW-1:0] window_len = '0;
    logic [CW-1:0] threshold = '0;
    logic          match_pulse;
    logic [CW-1:0] win_count;
    logic [CW-1:0] total_count;
    logic          window_done;
    logic          alarm;
    logic [TW-1:0] last_match_ts;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, plain integers and flags.
    bit      m_prev;
    bit      m_pulse;
    bit      m_done;
    bit      m_running;
    bit      m_alarmed;
    int      m_total;
    int      m_wc;
    int      m_cyc;
    longint  m_tsctr;
    longint  m_last_ts;

    seq_match_event_counter #(
        .CNT_W (CW),
        .WIN_W (WW),
        .TS_W  (TW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .det_in        (det_in),
        .en            (en),
        .clr           (clr),
        .window_len    (window_len),
        .threshold     (threshold),
        .match_pulse   (match_pulse),
        .win_count     (win_count),
        .total_count   (total_count),
        .window_done   (window_done),
        .alarm         (alarm),
        .last_match_ts (last_match_ts)
    );

    always #5 clk = ~clk;

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_prev    = 1'b1;
        m_pulse   = 1'b0;
        m_done    = 1'b0;
        m_running = 1'b0;
        m_alarmed = 1'b0;
        m_total   = 0;
        m_wc      = 0;
        m_cyc     = 0;
        m_tsctr   = 0;
        m_last_ts = 0;
    endtask

    // One clock edge of behaviour, using the inputs held across that edge.
    task automatic model_edge();
        bit rise;
        int post;
        rise    = det_in && !m_prev;
        m_prev  = det_in;
        m_pulse = rise;
        m_done  = 1'b0;
        if (clr) m_last_ts = 0;
        else if (rise) m_last_ts = m_tsctr;
        m_tsctr = (m_tsctr + 1) % (64'd1 << TW);
        if (clr) begin
            m_total = 0; m_wc = 0; m_cyc = 0; m_running = 0; m_alarmed = 0;
        end else begin
            if (rise) m_total = sat_inc(m_total);
            if (m_alarmed) begin
                // frozen until clr
            end else if (!m_running) begin
                m_wc = 0; m_cyc = 0; m_running = en;
            end else begin
                post = rise ? sat_inc(m_wc) : m_wc;
                if (threshold != 0 && post >= int'(threshold)) begin
                    m_wc = post; m_alarmed = 1;
                end else if (window_len != 0 && m_cyc == int'(window_len) - 1) begin
                    m_done = 1; m_wc = 0; m_cyc = 0; m_running = en;
                end else if (!en) begin
                    m_running = 0; m_wc = 0; m_cyc = 0;
                end else begin
                    m_cyc++; m_wc = post;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        det_in = 1'b0; en = 1'b0; clr = 1'b0;
        window_len = '0; threshold = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({match_pulse, window_done, alarm} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {match_pulse, window_done, alarm});
        end
        n_checks++;
        if (win_count !== '0 || total_count !== '0 || last_match_ts !== '0) begin
            n_fail++; $display("FAIL reset_counts: got win=%0d total=%0d ts=%0d expected 0", win_count, total_count, last_match_ts);
        end
    endtask

    task automatic test_edge_detect();
        int pulses = 0;
        apply_reset();
        det_in = 1'b1;
        repeat (5) begin step(); pulses += match_pulse; end
        det_in = 1'b0;
        repeat (2) begin step(); pulses += match_pulse; end
        det_in = 1'b1;
        repeat (3) begin step(); pulses += match_pulse; end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++; $display("FAIL edge_pulses: got %0d expected 1", pulses);
        end
        n_checks++;
        if (total_count !== 8'd1) begin
            n_fail++; $display("FAIL edge_total: got %0d expected 1", total_count);
        end
        det_in = 1'b0;
        step();
    endtask

    task automatic test_alarm();
        do_clr();
        en = 1'b1; window_len = 16'd20; threshold = 8'd3;
        for (int c = 0; c <= 10; c++) begin
            det_in = (c == 2 || c == 6 || c == 10);
            step();
            if (c == 9) begin
                n_checks++;
                if (alarm !== 1'b0) begin
                    n_fail++; $display("FAIL alarm_early: got %b expected 0", alarm);
                end
            end
        end
        n_checks++;
        if (alarm !== 1'b1 || win_count !== 8'd3) begin
            n_fail++; $display("FAIL alarm_hit: got alarm=%b win=%0d expected alarm=1 win=3", alarm, win_count);
        end
        en = 1'b0;
        for (int c = 0; c < 30; c++) begin
            det_in = c[0];
            step();
        end
        n_checks++;
        if (alarm !== 1'b1 || win_count !== 8'd3 || window_done !== 1'b0) begin
            n_fail++; $display("FAIL alarm_hold: got alarm=%b win=%0d done=%b expected 1 3 0", alarm, win_count, window_done);
        end
        det_in = 1'b0;
        do_clr();
        n_checks++;
        if (alarm !== 1'b0 || win_count !== '0 || total_count !== '0) begin
            n_fail++; $display("FAIL alarm_clr: got alarm=%b win=%0d total=%0d expected 0 0 0", alarm, win_count, total_count);
        end
    endtask

    task automatic test_window();
        bit seen = 0;
        do_clr();
        en = 1'b1; window_len = 16'd10; threshold = 8'd3;
        for (int c = 0; c < 30 && !seen; c++) begin
            det_in = (c == 3 || c == 5);
            step();
            if (window_done) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL window_done_timeout: got no pulse in 30 cycles expected one");
        end
        n_checks++;
        if (win_count !== '0 || alarm !== 1'b0 || total_count !== 8'd2) begin
            n_fail++; $display("FAIL window_close: got win=%0d alarm=%b total=%0d expected 0 0 2", win_count, alarm, total_count);
        end
        det_in = 1'b1; step();
        n_checks++;
        if (win_count !== 8'd1 || window_done !== 1'b0) begin
            n_fail++; $display("FAIL window_continue: got win=%0d done=%b expected 1 0", win_count, window_done);
        end
        det_in = 1'b0; en = 1'b0; step();
    endtask

    task automatic test_saturation();
        bit alarm_seen = 0;
        do_clr();
        en = 1'b1; window_len = '0; threshold = '0;
        repeat (300) begin
            det_in = 1'b1; step(); alarm_seen |= alarm;
            det_in = 1'b0; step(); alarm_seen |= alarm;
        end
        n_checks++;
        if (total_count !== 8'd255 || win_count !== 8'd255) begin
            n_fail++; $display("FAIL saturation: got total=%0d win=%0d expected 255 255", total_count, win_count);
        end
        n_checks++;
        if (alarm_seen !== 1'b0) begin
            n_fail++; $display("FAIL sat_alarm: got alarm seen=%b expected 0", alarm_seen);
        end
        en = 1'b0;
    endtask

    task automatic test_clr_with_rise();
        do_clr();
        repeat (7) begin
            det_in = 1'b1; step();
            det_in = 1'b0; step();
        end
        n_checks++;
        if (total_count !== 8'd7) begin
            n_fail++; $display("FAIL clr_pre: got total=%0d expected 7", total_count);
        end
        det_in = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks++;
        if (total_count !== '0 || match_pulse !== 1'b1) begin
            n_fail++; $display("FAIL clr_rise: got total=%0d pulse=%b expected 0 1", total_count, match_pulse);
        end
        det_in = 1'b0; step();
    endtask

    task automatic test_rst_mid_run();
        en = 1'b1; window_len = 16'd50; threshold = '0;
        det_in = 1'b1; step();
        det_in = 1'b0; step();
        det_in = 1'b1; step();
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({match_pulse, window_done, alarm} !== 3'b000 || win_count !== '0 || total_count !== '0 || last_match_ts !== '0) begin
            n_fail++; $display("FAIL rst_mid: got pulse=%b done=%b alarm=%b win=%0d total=%0d ts=%0d expected all 0",
                               match_pulse, window_done, alarm, win_count, total_count, last_match_ts);
        end
        apply_reset();
    endtask

    task automatic test_timestamp();
        apply_reset();
        while (m_tsctr != 41) step();
        det_in = 1'b1; step();
        det_in = 1'b0; step();
        n_checks++;
`ifdef MATCH_TIMESTAMP_EN
        if (last_match_ts !== 32'd41) begin
            n_fail++; $display("FAIL ts_capture: got %0d expected 41", last_match_ts);
        end
`else
        if (last_match_ts !== '0) begin
            n_fail++; $display("FAIL ts_tied: got %0d expected 0", last_match_ts);
        end
`endif
    endtask

    task automatic test_random();
        logic [TW-1:0] exp_ts;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                window_len = 16'($urandom_range(0, 12));
                threshold  = 8'($urandom_range(0, 6));
            end
            det_in = ($urandom_range(0, 2) != 0) ? ~det_in : det_in;
            en     = ($urandom_range(0, 9) != 0);
            clr    = ($urandom_range(0, 99) == 0);
            step();
`ifdef MATCH_TIMESTAMP_EN
            exp_ts = TW'(m_last_ts);
`else
            exp_ts = '0;
`endif
            n_checks++;
            if (match_pulse !== m_pulse || window_done !== m_done || alarm !== m_alarmed) begin
                n_fail++; $display("FAIL rand_flags c=%0d: got pulse=%b done=%b alarm=%b expected %b %b %b",
                                   c, match_pulse, window_done, alarm, m_pulse, m_done, m_alarmed);
            end
            n_checks++;
            if (win_count !== CW'(m_wc) || total_count !== CW'(m_total) || last_match_ts !== exp_ts) begin
                n_fail++; $display("FAIL rand_counts c=%0d: got win=%0d total=%0d ts=%0d expected %0d %0d %0d",
                                   c, win_count, total_count, last_match_ts, m_wc, m_total, exp_ts);
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge_detect();
        test_alarm();
        test_window();
        test_saturation();
        test_clr_with_rise();
        test_rst_mid_run();
        test_timestamp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
